// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
//
// Sequential signed MxM multiplier that sits beside the ALU. It runs one
// shift-and-add step per clock on the operand magnitudes, then applies the
// sign in a final fix-up step. The flags use the same format as the
// combinational ALU units.
//
// The operation is driven by a start/busy/done handshake:
//   IDLE -> CALC (M steps) -> FIX -> DONE -> IDLE
//
// Timing, with t0 as the clock edge that accepts start:
//   - busy is high after t0 and stays high through CALC and FIX.
//   - done is high for one cycle, right after edge t0+M+1.
//   - The next start can be accepted at edge t0+M+3 at the earliest.
//   - start is ignored in every state except IDLE.
//   - A and B are used only at t0, so they may change afterwards.
//
// Ports
//   clk    in   1     system clock, rising edge
//   rst    in   1     synchronous reset, active-high; overrides all inputs
//   start  in   1     multiply request, sampled only in IDLE
//   A      in   M     signed multiplicand, captured on the accepted edge
//   B      in   M     signed multiplier, captured on the accepted edge
//   busy   out  1     high while in CALC or FIX
//   done   out  1     one-cycle pulse when R and the flags update
//   R      out  2M    signed product, held until the next done
//   C      out  1     magnitude spilled past M bits: |mag[2M-1:M]
//   N      out  1     R[2M-1]
//   V      out  1     R does not fit in M-bit signed: R[2M-1:M-1] not uniform
//   Z      out  1     R == 0
// -----------------------------------------------------------------------------
module mult_seq_ctrl #(
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [M-1:0]   A,
    input  logic [M-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*M-1:0] R,
    output logic           C,
    output logic           N,
    output logic           V,
    output logic           Z
);

    localparam int CW = (M > 2) ? $clog2(M) : 1;
    localparam int PW = 2 * M;
    localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e          state_q;
    logic [M-1:0]    mcand_q;
    logic [M-1:0]    mplr_q;
    logic            sgn_q;
    logic [PW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;

    logic            busy_q;
    logic            done_q;
    logic [PW-1:0]   r_q;
    logic            c_q;
    logic            n_q;
    logic            v_q;
    logic            z_q;

    // Magnitude as an M-bit unsigned value. The most negative input,
    // -2^(M-1), maps to 2^(M-1), which still fits in M unsigned bits.
    function automatic logic [M-1:0] magnitude(input logic [M-1:0] x);
        return x[M-1] ? (~x + M'(1)) : x;
    endfunction

    logic [M-1:0]  mag_a_d;
    logic [M-1:0]  mag_b_d;
    logic [PW-1:0] addend_d;
    logic [PW-1:0] acc_d;
    logic [PW-1:0] r_d;
    logic          c_d;
    logic          n_d;
    logic          v_d;
    logic          z_d;

    // NOTE: every signal assigned in this block gets a value on every path,
    // so no latch can be inferred.
    always_comb begin
        mag_a_d  = magnitude(A);
        mag_b_d  = magnitude(B);

        // One shift-and-add step: add the shifted multiplicand when the
        // current multiplier LSB is set. |A|*|B| <= 2^(2M-2), so the sum
        // always fits in PW bits.
        addend_d = {{M{1'b0}}, mcand_q} << cnt_q;
        acc_d    = mplr_q[0] ? (acc_q + addend_d) : acc_q;

        // Sign fix-up. Negating a zero magnitude gives zero again, so a
        // zero product with sgn=1 still comes out as R=0, Z=1, N=0.
        r_d      = sgn_q ? (~acc_q + PW'(1)) : acc_q;

        c_d      = |acc_q[PW-1:M];
        n_d      = r_d[PW-1];
        v_d      = !((&r_d[PW-1:M-1]) || !(|r_d[PW-1:M-1]));
        z_d      = (r_d == '0);
    end

    // The controller and all of its registered outputs live in one
    // clocked process.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are reset as well, so a reset
            // in the middle of an operation leaves nothing stale behind.
            state_q <= IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            sgn_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            r_q     <= '0;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q <= mag_a_d;
                        mplr_q  <= mag_b_d;
                        sgn_q   <= A[M-1] ^ B[M-1];
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end

                CALC: begin
                    acc_q  <= acc_d;
                    mplr_q <= mplr_q >> 1;
                    cnt_q  <= cnt_q + CW'(1);
                    // The step that uses cnt == M-1 is the last of M steps.
                    if (cnt_q == CNT_LAST) begin
                        state_q <= FIX;
                    end
                end

                FIX: begin
                    r_q     <= r_d;
                    c_q     <= c_d;
                    n_q     <= n_d;
                    v_q     <= v_d;
                    z_q     <= z_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end

                DONE: begin
                    // This extra state keeps done to a single-cycle pulse
                    // and stops a held start from giving back-to-back pulses.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign R    = r_q;
    assign C    = c_q;
    assign N    = n_q;
    assign V    = v_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_seq_ctrl
//
// Directed testbench for mult_seq_ctrl with M=4. The expected products and
// flags are computed by hand from the signed operands.
// -----------------------------------------------------------------------------
module tb_mult_seq_ctrl;

    localparam int M      = 4;
    localparam int LAT    = M + 1;   // edges from the accepting edge t0 to done
    localparam int PERIOD = M + 3;   // done-to-done spacing when start is held

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [M-1:0]   A;
    logic [M-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*M-1:0] R;
    logic           C;
    logic           N;
    logic           V;
    logic           Z;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.M(M)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .R     (R),
        .C     (C),
        .N     (N),
        .V     (V),
        .Z     (Z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Step to 1 time unit after the next rising edge, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until done is seen or the budget runs out. A timeout makes k
    // too large, and the caller's latency check then reports it.
    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 30) begin
            tick();
            k++;
        end
    endtask

    task automatic run_op(input string tag, input logic [M-1:0] a, input logic [M-1:0] b,
                          input logic [2*M-1:0] er, input logic ec, input logic en,
                          input logic ev, input logic ez);
        int k;
        A     = a;
        B     = b;
        start = 1'b1;
        tick();                // the accepting edge t0
        start = 1'b0;
        A     = ~a;            // the operands are free to change now
        B     = ~b;
        check({tag, " busy"}, 32'(busy), 32'd1);
        wait_done(k);
        check({tag, " latency"}, 32'(k), 32'(LAT));
        check({tag, " R"}, 32'(R), 32'(er));
        check({tag, " C"}, 32'(C), 32'(ec));
        check({tag, " N"}, 32'(N), 32'(en));
        check({tag, " V"}, 32'(V), 32'(ev));
        check({tag, " Z"}, 32'(Z), 32'(ez));
        tick();
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        int n_done;
        logic [2*M-1:0] r_seen;

        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset R",    32'(R),    32'd0);
        check("reset CNVZ", 32'({C, N, V, Z}), 32'd0);
        rst = 1'b0;
        tick();

        // Basic signed products and the corner cases.
        run_op("3*5",   4'h3, 4'h5, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("-3*5",  4'hD, 4'h5, 8'hF1, 1'b0, 1'b1, 1'b1, 1'b0);
        run_op("2*-3",  4'h2, 4'hD, 8'hFA, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("-8*-8", 4'h8, 4'h8, 8'h40, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("0*-7",  4'h0, 4'h9, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("-1*-1", 4'hF, 4'hF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("-8*7",  4'h8, 4'h7, 8'hC8, 1'b1, 1'b1, 1'b1, 1'b0);
        run_op("7*-3",  4'h7, 4'hD, 8'hEB, 1'b1, 1'b1, 1'b1, 1'b0);

        // A second start pulse during CALC, with new operands, is ignored.
        A = 4'h3; B = 4'h5; start = 1'b1;
        tick();                // t0
        start = 1'b0;
        tick();                // after t0+1, in CALC
        A = 4'h7; B = 4'h7; start = 1'b1;
        tick();
        start = 1'b0;
        n_done = 0;
        r_seen = '0;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                n_done++;
                r_seen = R;
            end
            tick();
        end
        check("ignore done count", 32'(n_done), 32'd1);
        check("ignore R",          32'(r_seen), 32'h0F);

        // A reset at the second CALC edge discards the operation.
        A = 4'h5; B = 4'h3; start = 1'b1;
        tick();                // t0
        start = 1'b0;
        tick();                // after t0+1
        rst = 1'b1;
        tick();                // t0+2 samples the reset
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst R",    32'(R),    32'd0);
        check("midrst CNVZ", 32'({C, N, V, Z}), 32'd0);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) n_done++;
            tick();
        end
        check("midrst no done", 32'(n_done), 32'd0);
        run_op("post-rst 2*-3", 4'h2, 4'hD, 8'hFA, 1'b0, 1'b1, 1'b0, 1'b0);

        // With start held high, a new op is accepted every M+3 cycles,
        // and each op gives exactly one done.
        A = 4'hD; B = 4'h5; start = 1'b1;
        wait_done(k);
        check("held first R", 32'(R), 32'hF1);
        for (int j = 0; j < 2; j++) begin
            tick();
            k = 1;
            while (!done && k < 30) begin
                tick();
                k++;
            end
            check("held period", 32'(k), 32'(PERIOD));
            check("held R",      32'(R), 32'hF1);
        end
        start = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("held end busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
